prog_clock_divider: RTL and testbench
=====================================

# prog_clock_divider

Runtime-programmable clock divider and tick generator. It is the parametrised successor to the fixed 100 MHz to 1 Hz divider. It produces a one-cycle `tick` strobe every `cur_div` enabled cycles and a square-wave `clk_out` that toggles on each tick. The divisor can be reloaded at run time without glitches: a new value is held pending and takes effect only at the next counter wrap. It sits between the board clock and timebase consumers such as BCD counters, display multiplexers and debouncers, and replaces per-consumer hardcoded dividers.

## Interface
Parameters:
- `WIDTH`, 27: width of the counter and of all divisor paths.
- `DEFAULT_DIV`, 100000000: divisor loaded at reset. Legal range is 1 to 2^WIDTH-1.

Ports:
- `clk_in` input 1: the single clock. All logic is on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `en` input 1: count enable. While low, the counter and outputs hold.
- `sclr` input 1: synchronous clear of the count state.
- `div_in` input WIDTH: new divisor value.
- `div_load` input 1: one-cycle strobe that captures `div_in` into the pending register.
- `tick` output 1: registered strobe, high for exactly one cycle per wrap.
- `clk_out` output 1: registered square wave with period 2·`cur_div` enabled cycles.
- `cur_div` output WIDTH: divisor currently in effect.
- `div_busy` output 1: high while a loaded divisor is pending and not yet applied.

## Operation
Internal state:
- `cnt` (WIDTH bits)
- `pend` (WIDTH bits)
- a pending flag, which drives `div_busy`

Reset (`reset_n` low, asynchronous):
- `cnt` = 0, `tick` = 0, `clk_out` = 0, `div_busy` = 0.
- `cur_div` = DEFAULT_DIV, `pend` = DEFAULT_DIV.

Priority per rising edge, highest first:
1. `sclr`
2. counting (`en`)
3. hold

`sclr` high:
- Sets `cnt` = 0, `tick` = 0, `clk_out` = 0.
- Leaves `cur_div`, `pend` and `div_busy` unchanged.
- `div_load` is still honoured on the same edge.

`en` high, `sclr` low:
- If `cnt` == `cur_div`-1, a wrap occurs: `cnt` ← 0, `tick` ← 1, `clk_out` ← ~`clk_out`.
- Otherwise `cnt` ← `cnt`+1 and `tick` ← 0.

`en` low, `sclr` low:
- `cnt` and `clk_out` hold.
- `tick` ← 0.

Divisor load (`div_load` high on an edge):
- `pend` ← `div_in`, except that `div_in` = 0 is stored as 1.
- `div_busy` ← 1.
- The load is accepted regardless of `en`.

Divisor apply:
- On a wrap edge with `div_busy` = 1, `cur_div` ← `pend` and `div_busy` ← 0.
- The value applied is the one `pend` held before that edge.
- If a load and a wrap fall on the same edge, the pending value that existed before the edge (if any) is applied. The new load then becomes pending and `div_busy` stays 1. If nothing was pending, only the new value becomes pending.
- A second load before apply overwrites `pend`; the last value wins.
- Apply happens only on a wrap. While `en` is low, the divisor stays pending.

Invariant: `cnt` < `cur_div` at all times, because `cur_div` changes only when `cnt` goes to 0.

`cur_div` = 1:
- Every enabled edge is a wrap.
- `tick` stays high continuously while `en` is high.
- `clk_out` toggles every enabled cycle.

Arithmetic:
- Unsigned, WIDTH bits.
- `cur_div`-1 never underflows because `cur_div` ≥ 1.

## Timing
- All outputs are registered, with no combinational path from input to output.
- From reset release with `en` held high, the first `tick` and the first `clk_out` rise occur on the `cur_div`-th rising edge.
- `tick` is asserted in the same cycle that `cnt` reads 0 after a wrap.
- `tick` period is `cur_div` enabled cycles. `clk_out` period is 2·`cur_div` enabled cycles at 50% duty.
- Load latency: `div_busy` rises on the edge that samples `div_load`.
- Apply latency: between 1 and old `cur_div` enabled edges after the load.
- The first period at the new divisor begins at `cnt` = 0 on the apply edge. No short or runt period is ever produced.
- Reset asserted mid-count clears the block immediately and discards any pending divisor.

## Test plan
- Reset with DEFAULT_DIV overridden to 4, `en` = 1 → `tick` high on edges 4, 8 and 12; `clk_out` reads 0,0,0,1,1,1,1,0…; `cur_div` = 4, `div_busy` = 0.
- `cur_div` = 4, pulse `div_load` with `div_in` = 2 at `cnt` = 1 → `div_busy` = 1 for 3 cycles; apply on the wrap edge; subsequent ticks every 2 cycles; no runt period.
- `div_load` with `div_in` = 0 → after the next wrap, `cur_div` = 1, `tick` stays high continuously, and `clk_out` toggles every cycle.
- `cur_div` = 3, drop `en` at `cnt` = 1 for 5 cycles → `cnt`, `clk_out` and `div_busy` hold, `tick` = 0; the count resumes at 2 and the wrap occurs on the second edge after `en` returns.
- `cur_div` = 4 with 6 already pending, then load 5 on the wrap edge → `cur_div` = 6 and `div_busy` stays 1; 5 is applied 6 cycles later.
- Assert `sclr` at `cnt` = 2 with `clk_out` = 1, then assert `reset_n` low mid-count with 7 pending → after `sclr`: `cnt` = 0, `clk_out` = 0, `cur_div` and `div_busy` unchanged; after reset: all outputs at their reset values, `cur_div` = DEFAULT_DIV, `div_busy` = 0.

Source files
------------

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider: one-cycle tick every cur_div enabled cycles,
// a 50% square wave toggling on each tick, and a glitch-free divisor reload at wrap.
module prog_clock_divider #(
  parameter int unsigned        WIDTH       = 27,
  parameter logic [WIDTH-1:0]   DEFAULT_DIV = WIDTH'(100000000)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sclr,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             tick,
  output logic             clk_out,
  output logic [WIDTH-1:0] cur_div,
  output logic             div_busy
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend;
  logic             wrap;

  // A zero divisor would make the wrap compare underflow, so it is promoted to 1.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
    return (d == '0) ? WIDTH'(1) : d;
  endfunction

  always_comb begin
    wrap = 1'b0;
    if (!sclr && en && (cnt == cur_div - WIDTH'(1)))
      wrap = 1'b1;
  end

  // Count, tick and square-wave state
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (sclr) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= ~clk_out;
      end else begin
        cnt     <= cnt + WIDTH'(1);
        tick    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // Divisor pending/apply: the value pending before a wrap edge is the one applied,
  // so a load landing on that same edge simply becomes the next pending value.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cur_div  <= DEFAULT_DIV;
      pend     <= DEFAULT_DIV;
      div_busy <= 1'b0;
    end else begin
      if (wrap && div_busy)
        cur_div <= pend;
      if (div_load) begin
        pend     <= clamp_div(div_in);
        div_busy <= 1'b1;
      end else if (wrap) begin
        div_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider with DEFAULT_DIV = 4 and an 8-bit datapath.
module tb_prog_clock_divider;

  localparam int W = 8;

  logic         clk_in;
  logic         reset_n;
  logic         en;
  logic         sclr;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         tick;
  logic         clk_out;
  logic [W-1:0] cur_div;
  logic         div_busy;

  int n_chk  = 0;
  int n_pass = 0;

  prog_clock_divider #(.WIDTH(W), .DEFAULT_DIV(8'd4)) dut (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .en       (en),
    .sclr     (sclr),
    .div_in   (div_in),
    .div_load (div_load),
    .tick     (tick),
    .clk_out  (clk_out),
    .cur_div  (cur_div),
    .div_busy (div_busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic chk_all(input string tag, input logic t, input logic c,
                         input logic [31:0] d, input logic b);
    chk({tag, "_tick"}, 32'(tick), 32'(t));
    chk({tag, "_clk"},  32'(clk_out), 32'(c));
    chk({tag, "_div"},  32'(cur_div), d);
    chk({tag, "_busy"}, 32'(div_busy), 32'(b));
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    en       = 1'b1;
    sclr     = 1'b0;
    div_in   = '0;
    div_load = 1'b0;
    #12;
    chk_all("rst", 1'b0, 1'b0, 4, 1'b0);
    @(posedge clk_in);
    #1 reset_n = 1'b1;

    // Edges 1..12 at div 4: ticks on 4, 8, 12; clk_out rises on 4, falls on 8
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("t1_tick_e%0d", k), 32'(tick), 32'(k % 4 == 0));
      chk($sformatf("t1_clk_e%0d", k), 32'(clk_out), 32'((k / 4) % 2));
    end
    chk_all("t1_end", 1'b1, 1'b1, 4, 1'b0);

    // Load 2 on the edge that takes cnt to 1; applied at the wrap on edge 16
    div_in = 8'd2; div_load = 1'b1;
    step(); div_load = 1'b0;                     // edge 13
    chk_all("t2_e13", 1'b0, 1'b1, 4, 1'b1);
    step();                                      // 14
    chk_all("t2_e14", 1'b0, 1'b1, 4, 1'b1);
    step();                                      // 15
    chk_all("t2_e15", 1'b0, 1'b1, 4, 1'b1);
    step();                                      // 16
    chk_all("t2_e16", 1'b1, 1'b0, 2, 1'b0);
    step(); chk_all("t2_e17", 1'b0, 1'b0, 2, 1'b0);
    step(); chk_all("t2_e18", 1'b1, 1'b1, 2, 1'b0);
    step(); chk_all("t2_e19", 1'b0, 1'b1, 2, 1'b0);
    step(); chk_all("t2_e20", 1'b1, 1'b0, 2, 1'b0);

    // Load 0 -> stored as 1; continuous tick, clk_out toggles every cycle
    div_in = 8'd0; div_load = 1'b1;
    step(); div_load = 1'b0;                     // 21
    chk_all("t3_e21", 1'b0, 1'b0, 2, 1'b1);
    step();                                      // 22
    chk_all("t3_e22", 1'b1, 1'b1, 1, 1'b0);
    for (int k = 23; k <= 26; k++) begin
      step();
      chk_all($sformatf("t3_e%0d", k), 1'b1, 1'(k % 2 == 0), 1, 1'b0);
    end

    // Load 3: pending on edge 27 (a wrap with nothing pending), applied on 28
    div_in = 8'd3; div_load = 1'b1;
    step(); div_load = 1'b0;                     // 27
    chk_all("t4_e27", 1'b1, 1'b0, 1, 1'b1);
    step();                                      // 28
    chk_all("t4_e28", 1'b1, 1'b1, 3, 1'b0);
    div_in = 8'd4; div_load = 1'b1;
    step(); div_load = 1'b0;                     // 29: cnt 1, 4 pending
    chk_all("t4_e29", 1'b0, 1'b1, 3, 1'b1);
    en = 1'b0;
    for (int k = 30; k <= 34; k++) begin
      step();
      chk_all($sformatf("t4_hold_e%0d", k), 1'b0, 1'b1, 3, 1'b1);
    end
    en = 1'b1;
    step();                                      // 35: cnt 2
    chk_all("t4_e35", 1'b0, 1'b1, 3, 1'b1);
    step();                                      // 36: wrap, apply 4
    chk_all("t4_e36", 1'b1, 1'b0, 4, 1'b0);

    // 6 pending, then load 5 on the wrap edge: 6 applies now, 5 after 6 more edges
    div_in = 8'd6; div_load = 1'b1;
    step(); div_load = 1'b0;                     // 37
    chk_all("t5_e37", 1'b0, 1'b0, 4, 1'b1);
    step(); step();                              // 38, 39
    chk_all("t5_e39", 1'b0, 1'b0, 4, 1'b1);
    div_in = 8'd5; div_load = 1'b1;
    step(); div_load = 1'b0;                     // 40
    chk_all("t5_e40", 1'b1, 1'b1, 6, 1'b1);
    for (int k = 41; k <= 45; k++) begin
      step();
      chk_all($sformatf("t5_e%0d", k), 1'b0, 1'b1, 6, 1'b1);
    end
    step();                                      // 46
    chk_all("t5_e46", 1'b1, 1'b0, 5, 1'b0);

    // Reach cnt 2 with clk_out high and 7 pending, then sclr
    for (int k = 47; k <= 50; k++) step();
    step();                                      // 51: wrap
    chk_all("t6_e51", 1'b1, 1'b1, 5, 1'b0);
    div_in = 8'd7; div_load = 1'b1;
    step(); div_load = 1'b0;                     // 52
    step();                                      // 53: cnt 2
    chk_all("t6_e53", 1'b0, 1'b1, 5, 1'b1);
    sclr = 1'b1;
    step(); sclr = 1'b0;                         // 54
    chk_all("t6_sclr", 1'b0, 1'b0, 5, 1'b1);
    step(); step();                              // 55, 56: cnt 2
    chk_all("t6_e56", 1'b0, 1'b0, 5, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_all("t6_rst", 1'b0, 1'b0, 4, 1'b0);
    @(posedge clk_in);
    #1 reset_n = 1'b1;
    // Pending 7 was discarded: period back to 4
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("t6_post_e%0d", k), 1'(k % 4 == 0), 1'((k / 4) % 2), 4, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
